// File: rtl/writeback_stage.sv
// Writeback stage for the 4-thread barrel core: merges unstallable ALU results with
// back-pressured load results (queued in a small FIFO) onto the register-file write port.
module writeback_stage #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [1:0]                    alu_thread,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [1:0]                    ld_thread,
  input  logic [4:0]                    ld_rd,
  input  logic [XLEN-1:0]               ld_data,
  output logic                          wr_en,
  output logic [1:0]                    thread_rd_id,
  output logic [4:0]                    rd_addr,
  output logic [XLEN-1:0]               new_data,
  output logic [$clog2(FIFO_DEPTH):0]   ld_fifo_count,
  output logic                          ld_starve
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [1:0]      thread;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t         mem [FIFO_DEPTH];
  wb_ent_t         head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wr_en_q, wr_en_d;
  logic [1:0]      thread_q, thread_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            push, pop;

  // Readiness uses only the registered count: a full FIFO refuses even while popping.
  assign ld_ready = !rst && (count_q < DEPTH_C);
  assign head     = mem[rd_ptr_q];

  always_comb begin
    push     = ld_valid && ld_ready;
    pop      = !alu_valid && (count_q != '0);
    wr_en_d  = 1'b0;
    thread_d = thread_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (alu_valid) begin
      wr_en_d  = (alu_rd != 5'd0);
      thread_d = alu_thread;
      rd_d     = alu_rd;
      data_d   = alu_data;
    end else if (pop) begin
      wr_en_d  = (head.rd != 5'd0);
      thread_d = head.thread;
      rd_d     = head.rd;
      data_d   = head.data;
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (pop || count_q == '0)   starve_d = '0;
    else if (starve_q < LIMIT_C) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wr_en_q  <= 1'b0;
      thread_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_en_q  <= wr_en_d;
      thread_q <= thread_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{thread: ld_thread, rd: ld_rd, data: ld_data};
  end

  assign wr_en         = wr_en_q;
  assign thread_rd_id  = thread_q;
  assign rd_addr       = rd_q;
  assign new_data      = data_q;
  assign ld_fifo_count = count_q;
  assign ld_starve     = (starve_q == LIMIT_C);
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the 4-thread barrel core. Drives the register file write port: wr_en, thread_rd_id, rd_addr, new_data.
- Merges two result sources: single-cycle ALU results, which cannot be back-pressured, and load results, which can be.
- Load results queue in a small FIFO and drain on cycles the ALU leaves idle.
- Writes to x0 are suppressed here.
- A starvation flag tells issue logic to insert a bubble.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 4, load-result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8, cycles the FIFO head may wait before ld_starve asserts.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_thread  in  2  thread id of ALU result.
- alu_rd  in  5  destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  FIFO can accept; transfer when ld_valid && ld_ready.
- ld_thread  in  2  thread id of load result.
- ld_rd  in  5  destination register.
- ld_data  in  XLEN  load data.
- wr_en  out  1  register-file write strobe (registered).
- thread_rd_id  out  2  thread of write (registered).
- rd_addr  out  5  destination register (registered).
- new_data  out  XLEN  write data (registered).
- ld_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ld_starve  out  1  FIFO head has waited ≥ STARVE_LIMIT cycles.

Behaviour:
- Reset (async, immediate):
  - wr_en=0, thread_rd_id=0, rd_addr=0, new_data=0.
  - FIFO emptied (pointers and count 0), starve counter=0, ld_starve=0.
  - ld_ready=0 while rst high; returns to 1 on the first cycle after release.
  - Reset mid-operation discards all queued loads; none are written.
- ld_ready = !rst && (count < FIFO_DEPTH). It depends only on registered count, not on a same-cycle pop, so a full FIFO refuses a push even in a cycle it pops.
- Push: on ld_valid && ld_ready, {ld_thread, ld_rd, ld_data} is written at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Selection each cycle, priority fixed:
  - (1) alu_valid: ALU result selected; FIFO not popped.
  - (2) else if count>0: FIFO head selected and popped.
  - (3) else: nothing selected.
- Output register, next edge:
  - wr_en = selected && (rd != 0).
  - thread_rd_id, rd_addr, new_data = selected fields.
  - When nothing is selected: wr_en=0; thread_rd_id, rd_addr and new_data hold their previous values.
- rd==0 entries are still consumed (popped) but produce wr_en=0.
- Latency:
  - ALU: 1 cycle (input at edge N, wr_en visible after edge N+1).
  - Load: minimum 2 cycles. Push at edge N, pop selected in cycle N+1, write visible after edge N+2.
- Count: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- Starve counter:
  - Increments each cycle count>0 and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on any pop or when count==0.
  - ld_starve = (counter == STARVE_LIMIT), registered.
  - Issue logic must deassert alu_valid for one cycle in response; the pop then clears the flag next cycle.
- Ordering: per-thread WAW between ALU and pending loads is upstream's responsibility; this block imposes no ordering between the sources. FIFO order among loads is strict.

Test Plan:
- Reset release, then alu_valid with thread 2, rd 5, data 0xDEADBEEF → one cycle later wr_en=1, thread_rd_id=2, rd_addr=5, new_data=0xDEADBEEF; then wr_en=0 when alu_valid=0.
- ALU idle; push load thread 1, rd 7, data 0x1234 → ld_fifo_count=1; two edges after push wr_en=1 with {1, 7, 0x1234}; count returns to 0.
- alu_valid held high while 5 loads are offered → 4 accepted, ld_ready=0 with count=4. ld_starve rises after 8 waiting cycles. Drop alu_valid one cycle → head {first load} written, ld_starve clears, ld_ready=1.
- alu_rd=0 and a load with ld_rd=0 → both consumed, wr_en never asserts, FIFO count returns to 0.
- Full FIFO with a simultaneous pop and ld_valid → push refused that cycle (count 4→3), accepted the next cycle (count back to 4).
- Assert rst with 3 loads queued and wr_en pending → outputs zero immediately, count=0; after release no stale write ever appears.
